// File: rtl/riscv_pkg.sv
// Shared pipeline types: lane count, write-back source encodings and the
// per-lane control bundle carried from execute into memory.
package riscv_pkg;

   localparam int NUM_LANES = 2;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef struct packed {
      logic       valid;
      logic       regwrite;
      logic       memwrite;
      logic [1:0] resultsrc;
      logic [4:0] rd;
   } ex_mem_lane_t;

endpackage

// File: rtl/ex_mem_lane.sv
// One lane of the EX/MEM register: captures data and control, gating the
// side-effect bits by lane validity, squash and WAW kill.
module ex_mem_lane
   import riscv_pkg::*;
#(
   parameter int Size = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            squash,
   input  logic            waw_kill,
   input  ex_mem_lane_t    ctl_e,
   input  logic [Size-1:0] alu_e,
   input  logic [Size-1:0] wd_e,
   input  logic [Size-1:0] pc4_e,
   output ex_mem_lane_t    ctl_m,
   output logic [Size-1:0] alu_m,
   output logic [Size-1:0] wd_m,
   output logic [Size-1:0] pc4_m
);

   logic eff;
   assign eff = ctl_e.valid & ~squash;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctl_m <= '0;
         alu_m <= '0;
         wd_m  <= '0;
         pc4_m <= '0;
      end else if (flush) begin
         ctl_m.valid    <= 1'b0;
         ctl_m.regwrite <= 1'b0;
         ctl_m.memwrite <= 1'b0;
      end else if (!stall) begin
         ctl_m.valid     <= eff;
         // x0 is never written, and an older write shadowed by the younger lane is dropped
         ctl_m.regwrite  <= eff & ctl_e.regwrite & (ctl_e.rd != 5'd0) & ~waw_kill;
         ctl_m.memwrite  <= eff & ctl_e.memwrite;
         ctl_m.resultsrc <= ctl_e.resultsrc;
         ctl_m.rd        <= ctl_e.rd;
         alu_m           <= alu_e;
         wd_m            <= wd_e;
         pc4_m           <= pc4_e;
      end
   end

endmodule

// File: rtl/ex_mem_pipe.sv
// Dual-issue EX/MEM pipeline register with taken-branch redirect selection,
// same-destination WAW resolution and a saturating redirect counter.
module ex_mem_pipe
   import riscv_pkg::*;
#(
   parameter int Size = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            StallM,
   input  logic            FlushM,
   input  logic            ValidE_0,
   input  logic            ValidE_1,
   input  logic [Size-1:0] alu_out_0,
   input  logic [Size-1:0] alu_out_1,
   input  logic [Size-1:0] WriteDataE_0,
   input  logic [Size-1:0] WriteDataE_1,
   input  logic [Size-1:0] PCPlus4E_0,
   input  logic [Size-1:0] PCPlus4E_1,
   input  logic [Size-1:0] PCTargetE_0,
   input  logic [Size-1:0] PCTargetE_1,
   input  logic [4:0]      RdE_0,
   input  logic [4:0]      RdE_1,
   input  logic            RegWriteE_0,
   input  logic            RegWriteE_1,
   input  logic            MemWriteE_0,
   input  logic            MemWriteE_1,
   input  logic            mux1E_0,
   input  logic            mux1E_1,
   input  logic [1:0]      ResultSrcE_0,
   input  logic [1:0]      ResultSrcE_1,
   output logic [Size-1:0] ALUResultM_0,
   output logic [Size-1:0] ALUResultM_1,
   output logic [Size-1:0] WriteDataM_0,
   output logic [Size-1:0] WriteDataM_1,
   output logic [Size-1:0] PCPlus4M_0,
   output logic [Size-1:0] PCPlus4M_1,
   output logic [4:0]      RdM_0,
   output logic [4:0]      RdM_1,
   output logic [1:0]      ResultSrcM_0,
   output logic [1:0]      ResultSrcM_1,
   output logic            RegWriteM_0,
   output logic            RegWriteM_1,
   output logic            MemWriteM_0,
   output logic            MemWriteM_1,
   output logic            ValidM_0,
   output logic            ValidM_1,
   output logic            RedirectM,
   output logic [Size-1:0] RedirectPCM,
   output logic            FlushDE,
   output logic [15:0]     RedirectCnt
);

   ex_mem_lane_t [NUM_LANES-1:0]           ctl_e, ctl_m;
   logic [NUM_LANES-1:0][Size-1:0]         alu_e, wd_e, pc4_e;
   logic [NUM_LANES-1:0][Size-1:0]         alu_m, wd_m, pc4_m;
   logic [NUM_LANES-1:0]                   squash, waw_kill;

   assign ctl_e[0] = '{valid: ValidE_0, regwrite: RegWriteE_0, memwrite: MemWriteE_0,
                       resultsrc: ResultSrcE_0, rd: RdE_0};
   assign ctl_e[1] = '{valid: ValidE_1, regwrite: RegWriteE_1, memwrite: MemWriteE_1,
                       resultsrc: ResultSrcE_1, rd: RdE_1};
   assign alu_e = {alu_out_1, alu_out_0};
   assign wd_e  = {WriteDataE_1, WriteDataE_0};
   assign pc4_e = {PCPlus4E_1, PCPlus4E_0};

   // An older taken redirect kills the younger lane before anything else looks at it
   logic take0, live1, take1, redirect, waw;
   assign take0    = ValidE_0 & mux1E_0;
   assign live1    = ValidE_1 & ~take0;
   assign take1    = live1 & mux1E_1;
   assign redirect = take0 | take1;
   assign waw      = ValidE_0 & live1 & RegWriteE_0 & RegWriteE_1 &
                     (RdE_0 == RdE_1) & (RdE_0 != 5'd0);

   assign squash   = {take0, 1'b0};
   assign waw_kill = {1'b0, waw};

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      ex_mem_lane #(.Size(Size)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .stall    (StallM),
         .flush    (FlushM),
         .squash   (squash[l]),
         .waw_kill (waw_kill[l]),
         .ctl_e    (ctl_e[l]),
         .alu_e    (alu_e[l]),
         .wd_e     (wd_e[l]),
         .pc4_e    (pc4_e[l]),
         .ctl_m    (ctl_m[l]),
         .alu_m    (alu_m[l]),
         .wd_m     (wd_m[l]),
         .pc4_m    (pc4_m[l])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         RedirectM   <= 1'b0;
         RedirectPCM <= '0;
         RedirectCnt <= '0;
      end else if (FlushM || StallM) begin
         RedirectM <= 1'b0;
      end else begin
         RedirectM <= redirect;
         if (redirect) begin
            RedirectPCM <= take0 ? PCTargetE_0 : PCTargetE_1;
            if (RedirectCnt != 16'hFFFF) RedirectCnt <= RedirectCnt + 16'd1;
         end
      end
   end

   assign FlushDE = RedirectM;

   assign ALUResultM_0 = alu_m[0];
   assign ALUResultM_1 = alu_m[1];
   assign WriteDataM_0 = wd_m[0];
   assign WriteDataM_1 = wd_m[1];
   assign PCPlus4M_0   = pc4_m[0];
   assign PCPlus4M_1   = pc4_m[1];
   assign RdM_0        = ctl_m[0].rd;
   assign RdM_1        = ctl_m[1].rd;
   assign ResultSrcM_0 = ctl_m[0].resultsrc;
   assign ResultSrcM_1 = ctl_m[1].resultsrc;
   assign RegWriteM_0  = ctl_m[0].regwrite;
   assign RegWriteM_1  = ctl_m[1].regwrite;
   assign MemWriteM_0  = ctl_m[0].memwrite;
   assign MemWriteM_1  = ctl_m[1].memwrite;
   assign ValidM_0     = ctl_m[0].valid;
   assign ValidM_1     = ctl_m[1].valid;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: stimulus pushes predicted register
// contents, an independent monitor compares each cycle after the edge.
module tb_ex_mem_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, StallM, FlushM;
   logic [1:0]       ve, rwe, mwe, mux;
   logic [1:0][31:0] alu, wd, p4, pct;
   logic [1:0][4:0]  rd;
   logic [1:0][1:0]  rs;

   logic [31:0] ALUResultM_0, ALUResultM_1, WriteDataM_0, WriteDataM_1;
   logic [31:0] PCPlus4M_0, PCPlus4M_1, RedirectPCM;
   logic [4:0]  RdM_0, RdM_1;
   logic [1:0]  ResultSrcM_0, ResultSrcM_1;
   logic RegWriteM_0, RegWriteM_1, MemWriteM_0, MemWriteM_1, ValidM_0, ValidM_1;
   logic RedirectM, FlushDE;
   logic [15:0] RedirectCnt;

   ex_mem_pipe #(.Size(32)) dut (
      .clk(clk), .rst_n(rst_n), .StallM(StallM), .FlushM(FlushM),
      .ValidE_0(ve[0]), .ValidE_1(ve[1]),
      .alu_out_0(alu[0]), .alu_out_1(alu[1]),
      .WriteDataE_0(wd[0]), .WriteDataE_1(wd[1]),
      .PCPlus4E_0(p4[0]), .PCPlus4E_1(p4[1]),
      .PCTargetE_0(pct[0]), .PCTargetE_1(pct[1]),
      .RdE_0(rd[0]), .RdE_1(rd[1]),
      .RegWriteE_0(rwe[0]), .RegWriteE_1(rwe[1]),
      .MemWriteE_0(mwe[0]), .MemWriteE_1(mwe[1]),
      .mux1E_0(mux[0]), .mux1E_1(mux[1]),
      .ResultSrcE_0(rs[0]), .ResultSrcE_1(rs[1]),
      .ALUResultM_0(ALUResultM_0), .ALUResultM_1(ALUResultM_1),
      .WriteDataM_0(WriteDataM_0), .WriteDataM_1(WriteDataM_1),
      .PCPlus4M_0(PCPlus4M_0), .PCPlus4M_1(PCPlus4M_1),
      .RdM_0(RdM_0), .RdM_1(RdM_1),
      .ResultSrcM_0(ResultSrcM_0), .ResultSrcM_1(ResultSrcM_1),
      .RegWriteM_0(RegWriteM_0), .RegWriteM_1(RegWriteM_1),
      .MemWriteM_0(MemWriteM_0), .MemWriteM_1(MemWriteM_1),
      .ValidM_0(ValidM_0), .ValidM_1(ValidM_1),
      .RedirectM(RedirectM), .RedirectPCM(RedirectPCM),
      .FlushDE(FlushDE), .RedirectCnt(RedirectCnt)
   );

   // Expected architectural view after an edge; dk marks lanes whose data is defined
   typedef struct {
      logic [1:0]       v, rw, mw, dk;
      logic [1:0][4:0]  rd;
      logic [1:0][1:0]  rs;
      logic [1:0][31:0] alu, wd, p4;
      logic             redir;
      logic [31:0]      rpc;
      int               cnt;
   } exp_t;

   exp_t m;
   exp_t q[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: describe what each lane means, not how the registers are built
   task automatic model_edge();
      if (!rst_n) begin
         m = '{v: '0, rw: '0, mw: '0, dk: 2'b11, rd: '0, rs: '0, alu: '0, wd: '0,
               p4: '0, redir: 1'b0, rpc: '0, cnt: 0};
      end else if (FlushM) begin
         m.v = '0; m.rw = '0; m.mw = '0; m.dk = '0; m.redir = 1'b0;
      end else if (StallM) begin
         m.redir = 1'b0;
      end else begin
         bit took0, real1, real0;
         real0 = ve[0];
         took0 = real0 && mux[0];
         real1 = ve[1] && !took0;
         m.v  = {real1, real0};
         m.mw = {real1 && mwe[1], real0 && mwe[0]};
         m.rw[1] = real1 && rwe[1] && rd[1] != 0;
         m.rw[0] = real0 && rwe[0] && rd[0] != 0 &&
                   !(m.rw[1] && rd[0] == rd[1]);
         m.rd = rd; m.rs = rs; m.alu = alu; m.wd = wd; m.p4 = p4; m.dk = 2'b11;
         if (took0) begin
            m.redir = 1'b1; m.rpc = pct[0];
         end else if (real1 && mux[1]) begin
            m.redir = 1'b1; m.rpc = pct[1];
         end else
            m.redir = 1'b0;
         if (m.redir && m.cnt < 65535) m.cnt++;
      end
   endtask

   task automatic step();
      model_edge();
      q.push_back(m);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      StallM = 0; FlushM = 0; ve = '0; rwe = '0; mwe = '0; mux = '0;
      alu = '0; wd = '0; p4 = '0; pct = '0; rd = '0; rs = '0;
   endtask

   task automatic rand_lanes();
      for (int l = 0; l < 2; l++) begin
         ve[l]  = $urandom_range(0, 3) != 0;
         rwe[l] = $urandom_range(0, 1);
         mwe[l] = $urandom_range(0, 1);
         mux[l] = $urandom_range(0, 3) == 0;
         rd[l]  = 5'($urandom_range(0, 3));
         rs[l]  = 2'($urandom_range(0, 3));
         alu[l] = $urandom; wd[l] = $urandom; p4[l] = $urandom; pct[l] = $urandom;
      end
   endtask

   // Monitor: one output set per edge
   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ValidM_0", 32'(ValidM_0), 32'(e.v[0]));
            chk("ValidM_1", 32'(ValidM_1), 32'(e.v[1]));
            chk("RegWriteM_0", 32'(RegWriteM_0), 32'(e.rw[0]));
            chk("RegWriteM_1", 32'(RegWriteM_1), 32'(e.rw[1]));
            chk("MemWriteM_0", 32'(MemWriteM_0), 32'(e.mw[0]));
            chk("MemWriteM_1", 32'(MemWriteM_1), 32'(e.mw[1]));
            chk("RedirectM", 32'(RedirectM), 32'(e.redir));
            chk("FlushDE", 32'(FlushDE), 32'(e.redir));
            chk("RedirectPCM", RedirectPCM, e.rpc);
            chk("RedirectCnt", 32'(RedirectCnt), 32'(e.cnt));
            if (e.dk[0]) begin
               chk("ALUResultM_0", ALUResultM_0, e.alu[0]);
               chk("WriteDataM_0", WriteDataM_0, e.wd[0]);
               chk("PCPlus4M_0", PCPlus4M_0, e.p4[0]);
               chk("RdM_0", 32'(RdM_0), 32'(e.rd[0]));
               chk("ResultSrcM_0", 32'(ResultSrcM_0), 32'(e.rs[0]));
            end
            if (e.dk[1]) begin
               chk("ALUResultM_1", ALUResultM_1, e.alu[1]);
               chk("WriteDataM_1", WriteDataM_1, e.wd[1]);
               chk("PCPlus4M_1", PCPlus4M_1, e.p4[1]);
               chk("RdM_1", 32'(RdM_1), 32'(e.rd[1]));
               chk("ResultSrcM_1", 32'(ResultSrcM_1), 32'(e.rs[1]));
            end
         end
      end
   end

   initial begin
      int budget;
      clear_in();
      rst_n = 0;
      step();
      step();
      rst_n = 1;

      // two valid lanes, plain capture
      ve = 2'b11; alu[0] = 32'h10; alu[1] = 32'h20; rd[0] = 1; rd[1] = 2; rwe = 2'b11;
      step();

      // older lane redirects, younger lane with a store is squashed
      clear_in();
      ve = 2'b11; mux[0] = 1; pct[0] = 32'h100; mwe[1] = 1; mux[1] = 1; pct[1] = 32'h200;
      step();
      clear_in();
      step();

      // younger lane redirects
      ve = 2'b11; mux[1] = 1; pct[1] = 32'h300;
      step();

      // three stalled cycles with changing inputs, then release
      for (int i = 0; i < 3; i++) begin
         rand_lanes(); StallM = 1;
         step();
      end
      StallM = 0; rand_lanes();
      step();

      // WAW on r5, then a write to x0
      clear_in();
      ve = 2'b11; rwe = 2'b11; rd[0] = 5; rd[1] = 5;
      step();
      rd[0] = 0; rd[1] = 7;
      step();

      // flush wins over stall
      rand_lanes(); ve = 2'b11; StallM = 1; FlushM = 1;
      step();

      // reset in the cycle a redirect would be captured
      clear_in(); ve = 2'b01; mux[0] = 1; pct[0] = 32'h444;
      step();
      rst_n = 0;
      step();
      rst_n = 1; clear_in();
      step();

      // random mix
      for (int i = 0; i < 400; i++) begin
         rand_lanes();
         StallM = $urandom_range(0, 4) == 0;
         FlushM = $urandom_range(0, 7) == 0;
         rst_n  = $urandom_range(0, 49) != 0;
         step();
      end
      rst_n = 1;

      // drive the counter into saturation
      clear_in(); ve = 2'b01; mux[0] = 1;
      for (int i = 0; i < 65540; i++) begin
         pct[0] = 32'(i);
         step();
      end
      clear_in();
      step();

      budget = 0;
      while (q.size() != 0 && budget < 10) begin
         @(posedge clk);
         budget++;
      end
      #4;
      if (q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain left=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SHALL have parameter Size, default 32, the datapath width of every data/PC field.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port StallM  input  1  hold all registered state.
REQ-005 SHALL have port FlushM  input  1  insert a bubble into both lanes.
REQ-006 SHALL have ports ValidE_0/ValidE_1  input  1  lane holds a real instruction; lane 1 is younger.
REQ-007 SHALL have ports alu_out_0/alu_out_1, WriteDataE_0/WriteDataE_1, PCPlus4E_0/PCPlus4E_1, PCTargetE_0/PCTargetE_1  input  Size  per-lane execute results.
REQ-008 SHALL have ports RdE_0/RdE_1  input  5  destination register.
REQ-009 SHALL have ports RegWriteE_0/RegWriteE_1, MemWriteE_0/MemWriteE_1, mux1E_0/mux1E_1  input  1  per-lane control and taken-redirect.
REQ-010 SHALL have ports ResultSrcE_0/ResultSrcE_1  input  2  write-back source select.
REQ-011 SHALL have ports ALUResultM_0/ALUResultM_1, WriteDataM_0/WriteDataM_1, PCPlus4M_0/PCPlus4M_1  output  Size  registered data.
REQ-012 SHALL have ports RdM_0/RdM_1 (5), ResultSrcM_0/ResultSrcM_1 (2), RegWriteM_0/RegWriteM_1, MemWriteM_0/MemWriteM_1, ValidM_0/ValidM_1 (1)  output  registered control.
REQ-013 SHALL have ports RedirectM  output  1 and RedirectPCM  output  Size  registered fetch redirect.
REQ-014 SHALL have port FlushDE  output  1  kill decode/execute stages; equals RedirectM.
REQ-015 SHALL have port RedirectCnt  output  16  saturating count of redirects taken.

Function
REQ-016 SHALL capture all lane fields on a rising edge when StallM=0 and FlushM=0; latency exactly 1 cycle.
REQ-017 SHALL hold every output register unchanged when StallM=1 and FlushM=0; RedirectM SHALL be 0 during stall-hold cycles.
REQ-018 SHALL, when FlushM=1 (regardless of StallM), clear ValidM_*, RegWriteM_*, MemWriteM_*, RedirectM on that edge; data fields don't-care.
REQ-019 SHALL treat an accepted lane as effective only when ValidE_x=1; ineffective lanes produce ValidM_x=0, RegWriteM_x=0, MemWriteM_x=0.
REQ-020 SHALL, if lane 0 effective and mux1E_0=1: RedirectM=1, RedirectPCM=PCTargetE_0, lane 1 squashed (as REQ-019), mux1E_1 ignored.
REQ-021 SHALL, else if lane 1 effective and mux1E_1=1: RedirectM=1, RedirectPCM=PCTargetE_1.
REQ-022 SHALL assert RedirectM for exactly one cycle per accepting edge; RedirectPCM holds its last value otherwise.
REQ-023 SHALL force RegWriteM_x=0 when RdE_x=0.
REQ-024 SHALL, when both lanes effective with RegWriteE=1 and RdE_0==RdE_1!=0, clear RegWriteM_0 (younger lane 1 wins WAW).
REQ-025 SHALL increment RedirectCnt by 1 on each edge setting RedirectM=1, saturating at 0xFFFF.

Reset
REQ-026 SHALL, on rising edge with rst_n=0, set all outputs and counters to 0 (RedirectPCM=0, RedirectCnt=0); reset overrides StallM and FlushM.
REQ-027 SHALL, on reset mid-redirect, drop RedirectM to 0 on the next edge without updating RedirectCnt.

Structure
REQ-028 SHALL take NUM_LANES=2, ResultSrc encoding constants and a per-lane struct ex_mem_lane_t from shared package riscv_pkg.
REQ-029 SHALL instantiate sub-module ex_mem_lane (one lane's register slice with valid/write-enable gating) once per lane; redirect/WAW/counter logic lives in ex_mem_pipe.

Verification
REQ-030 SHALL cover: both lanes valid, alu_out_0=0x10, alu_out_1=0x20, no redirect -> next cycle ALUResultM_0=0x10, ALUResultM_1=0x20, ValidM=11, RedirectM=0.
REQ-031 SHALL cover: mux1E_0=1, PCTargetE_0=0x100, lane 1 MemWriteE_1=1 -> RedirectM=1, RedirectPCM=0x100, ValidM_1=0, MemWriteM_1=0, FlushDE=1 one cycle.
REQ-032 SHALL cover: StallM=1 for 3 cycles with changing inputs -> outputs frozen, RedirectM=0; release -> new values captured next edge.
REQ-033 SHALL cover: RdE_0=RdE_1=5, both RegWrite -> RegWriteM_0=0, RegWriteM_1=1; RdE_0=0 -> RegWriteM_0=0.
REQ-034 SHALL cover: FlushM=1 with StallM=1 -> ValidM=00 next edge; 65536 redirects -> RedirectCnt stays 0xFFFF.
REQ-035 SHALL cover: rst_n=0 asserted in cycle of redirect capture -> all outputs 0 next edge, RedirectCnt=0.
